// File: rtl/shared_buffer_port_reader.sv
// shared_buffer_port_reader
// Read-side controller for the shared linked-list buffer. Snoops the write
// handshake to count complete packets per output port, drains one whole
// packet at a time in round-robin port order, and re-frames the returned
// words as a sop/eop/port stream through a 2-entry skid buffer.
module shared_buffer_port_reader #(
   parameter int N         = 13,
   parameter int NUM_PORTS = 8,
   parameter int LEN_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_req,
   input  logic [N-1:0] wr_ip,
   input  logic [7:0]   packet_len,
   output logic         rd_req,
   output logic [N-1:0] ip,
   input  logic [N-1:0] odata,
   input  logic         shared_buffer_empty,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic [N-1:0] out_port,
   output logic         out_sop,
   output logic         out_eop,
   input  logic         out_ready,
   output logic         len_overflow
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int AW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Length-FIFO pointer advance with explicit wrap.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(LEN_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Per-port status shared between the snoop logic and the scheduler.
   logic [NUM_PORTS-1:0] pend;
   logic [NUM_PORTS-1:0] port_pop;
   logic [NUM_PORTS-1:0] port_ovf;
   logic [7:0]           head_len [NUM_PORTS];

   // Scheduler state.
   state_t        state_reg, state_next;
   logic [N-1:0]  ip_reg, ip_next;
   logic [PW-1:0] last_reg, last_next;
   logic [7:0]    words_left_reg, words_left_next;
   logic          first_reg, first_next;
   logic          len_overflow_reg;

   // Round-robin pick.
   logic          pick_found;
   logic [PW-1:0] pick_idx;
   logic [PW-1:0] pick_cand;

   // In-flight word (issued last cycle, data arrives this cycle) and skid.
   logic         infl_valid_reg;
   logic         infl_sop_reg;
   logic         infl_eop_reg;
   logic [N-1:0] infl_port_reg;
   logic [N-1:0] skid_data_reg [2];
   logic [N-1:0] skid_port_reg [2];
   logic [1:0]   skid_sop_reg;
   logic [1:0]   skid_eop_reg;
   logic         skid_wr_reg;
   logic         skid_rd_reg;
   logic [1:0]   skid_count_reg;
   logic         out_pop;
   logic [2:0]   occ_after;
   logic         issue;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         logic [7:0]    rem_reg;
         logic [7:0]    cur_len_reg;
         logic [7:0]    len_mem [LEN_DEPTH];
         logic [AW-1:0] wr_ptr_reg;
         logic [AW-1:0] rd_ptr_reg;
         logic [CW-1:0] count_reg;
         logic          hit;
         logic          sop_word;
         logic          push_req;
         logic          push_ok;
         logic [7:0]    push_len;

         // A zero length on a packet's first word is ignored entirely.
         assign hit      = wr_req && (wr_ip == N'(gi));
         assign sop_word = hit && (rem_reg == 8'd0) && (packet_len != 8'd0);
         // Packet completes on a 1-word SOP or on the word taking rem to 0.
         assign push_req = (sop_word && (packet_len == 8'd1)) ||
                           (hit && (rem_reg == 8'd1));
         assign push_len = sop_word ? packet_len : cur_len_reg;
         assign push_ok  = push_req && (count_reg != CW'(LEN_DEPTH));

         assign port_ovf[gi] = push_req && (count_reg == CW'(LEN_DEPTH));
         assign pend[gi]     = (count_reg != '0);
         assign head_len[gi] = len_mem[rd_ptr_reg];

         // Snoop tracking and length-FIFO bookkeeping for this port.
         always_ff @(posedge clk) begin
            if (rst) begin
               rem_reg     <= '0;
               cur_len_reg <= '0;
               wr_ptr_reg  <= '0;
               rd_ptr_reg  <= '0;
               count_reg   <= '0;
            end else begin
               if (sop_word) begin
                  rem_reg     <= packet_len - 8'd1;
                  cur_len_reg <= packet_len;
               end else if (hit && (rem_reg != 8'd0)) begin
                  rem_reg <= rem_reg - 8'd1;
               end
               if (push_ok)
                  wr_ptr_reg <= ptr_inc(wr_ptr_reg);
               if (port_pop[gi])
                  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
               // Simultaneous push and pop leave occupancy unchanged.
               if (push_ok && !port_pop[gi])
                  count_reg <= count_reg + 1'b1;
               else if (!push_ok && port_pop[gi])
                  count_reg <= count_reg - 1'b1;
            end
         end

         // Length storage; entries beyond the count are don't-care.
         always_ff @(posedge clk) begin
            if (push_ok)
               len_mem[wr_ptr_reg] <= push_len;
         end
      end
   endgenerate

   // Round-robin search starting one past the last served port.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_cand  = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         pick_cand = PW'((int'(last_reg) + i) % NUM_PORTS);
         if (!pick_found && pend[pick_cand]) begin
            pick_found = 1'b1;
            pick_idx   = pick_cand;
         end
      end
   end

   // Issue only if the skid can absorb this word after counting the one in flight.
   always_comb begin
      out_pop   = (skid_count_reg != 2'd0) && out_ready;
      occ_after = {1'b0, skid_count_reg} + {2'b00, infl_valid_reg} - {2'b00, out_pop};
      issue     = (state_reg == ST_READ) && !shared_buffer_empty &&
                  (occ_after <= 3'd1) && (words_left_reg != 8'd0);
   end

   // Scheduler next-state: pick a port, stream its packet, then one drain cycle.
   always_comb begin
      state_next      = state_reg;
      ip_next         = ip_reg;
      last_next       = last_reg;
      words_left_next = words_left_reg;
      first_next      = first_reg;
      port_pop        = '0;
      unique case (state_reg)
         ST_IDLE: begin
            if (pick_found) begin
               port_pop[pick_idx] = 1'b1;
               words_left_next    = head_len[pick_idx];
               ip_next            = N'(pick_idx);
               last_next          = pick_idx;
               first_next         = 1'b1;
               state_next         = ST_READ;
            end
         end
         ST_READ: begin
            if (issue) begin
               words_left_next = words_left_reg - 8'd1;
               first_next      = 1'b0;
               if (words_left_reg == 8'd1)
                  state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The final word is in flight now and lands in the skid on this
            // edge, so the next packet can be picked right after.
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Scheduler state register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         ip_reg           <= '0;
         last_reg         <= PW'(NUM_PORTS - 1);
         words_left_reg   <= '0;
         first_reg        <= 1'b0;
         len_overflow_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         ip_reg           <= ip_next;
         last_reg         <= last_next;
         words_left_reg   <= words_left_next;
         first_reg        <= first_next;
         len_overflow_reg <= len_overflow_reg | (|port_ovf);
      end
   end

   // In-flight tag tracking and skid pointers/occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         infl_valid_reg <= 1'b0;
         infl_sop_reg   <= 1'b0;
         infl_eop_reg   <= 1'b0;
         infl_port_reg  <= '0;
         skid_wr_reg    <= 1'b0;
         skid_rd_reg    <= 1'b0;
         skid_count_reg <= '0;
      end else begin
         infl_valid_reg <= issue;
         infl_sop_reg   <= first_reg;
         infl_eop_reg   <= (words_left_reg == 8'd1);
         infl_port_reg  <= ip_reg;
         if (infl_valid_reg)
            skid_wr_reg <= ~skid_wr_reg;
         if (out_pop)
            skid_rd_reg <= ~skid_rd_reg;
         skid_count_reg <= skid_count_reg + {1'b0, infl_valid_reg} - {1'b0, out_pop};
      end
   end

   // Skid payload capture of the returned buffer word with its framing tags.
   always_ff @(posedge clk) begin
      if (infl_valid_reg) begin
         skid_data_reg[skid_wr_reg] <= odata;
         skid_port_reg[skid_wr_reg] <= infl_port_reg;
         skid_sop_reg[skid_wr_reg]  <= infl_sop_reg;
         skid_eop_reg[skid_wr_reg]  <= infl_eop_reg;
      end
   end

   assign rd_req       = issue;
   assign ip           = ip_reg;
   assign len_overflow = len_overflow_reg;
   assign out_valid    = (skid_count_reg != 2'd0);
   assign out_data     = out_valid ? skid_data_reg[skid_rd_reg] : '0;
   assign out_port     = out_valid ? skid_port_reg[skid_rd_reg] : '0;
   assign out_sop      = out_valid & skid_sop_reg[skid_rd_reg];
   assign out_eop      = out_valid & skid_eop_reg[skid_rd_reg];

endmodule

// File: tb/tb_shared_buffer_port_reader.sv
// Bench for shared_buffer_port_reader: a behavioural shared buffer returns
// words per port, expected framed words go into a queue, and a monitor pops
// and compares on every accepted output word.
module tb_shared_buffer_port_reader;
   localparam int N         = 13;
   localparam int NUM_PORTS = 8;

   typedef struct packed {
      logic [N-1:0] data;
      logic [N-1:0] port;
      logic         sop;
      logic         eop;
   } word_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_req;
   logic [N-1:0] wr_ip;
   logic [7:0]   packet_len;
   logic         rd_req;
   logic [N-1:0] ip;
   logic [N-1:0] odata;
   logic         shared_buffer_empty;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic [N-1:0] out_port;
   logic         out_sop;
   logic         out_eop;
   logic         out_ready;
   logic         len_overflow;

   logic [N-1:0] wr_data;
   logic         force_empty;
   logic [N-1:0] buf_q [NUM_PORTS][$];
   int           buf_words;
   word_t        exp_q [$];

   int errors   = 0;
   int checks   = 0;
   int rd_cnt   = 0;
   int out_cnt  = 0;
   int issued   = 0;
   int accepted = 0;

   shared_buffer_port_reader #(.N(N), .NUM_PORTS(NUM_PORTS), .LEN_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ip(wr_ip), .packet_len(packet_len),
      .rd_req(rd_req), .ip(ip), .odata(odata), .shared_buffer_empty(shared_buffer_empty),
      .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
      .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
      .len_overflow(len_overflow)
   );

   always #5 clk = ~clk;

   assign shared_buffer_empty = force_empty || (buf_words == 0);

   // Behavioural buffer: stores snooped writes per port, returns one word
   // the cycle after each rd_req.
   always @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) buf_q[p].delete();
         buf_words <= 0;
         odata     <= '0;
      end else begin
         if (rd_req && buf_q[ip[2:0]].size() != 0)
            odata <= buf_q[ip[2:0]].pop_front();
         if (wr_req && int'(wr_ip) < NUM_PORTS)
            buf_q[wr_ip[2:0]].push_back(wr_data);
         buf_words <= buf_words + ((wr_req && int'(wr_ip) < NUM_PORTS) ? 1 : 0)
                                - ((rd_req && buf_q[ip[2:0]].size() != 0) ? 1 : 0);
      end
   end

   // Monitor: scoreboard compare, outstanding bound, buffer read sanity.
   initial begin
      word_t e;
      word_t a;
      forever begin
         @(negedge clk);
         if (rst) begin
            issued   = 0;
            accepted = 0;
         end else begin
            if (rd_req) begin
               checks++;
               if (buf_q[ip[2:0]].size() == 0) begin
                  errors++;
                  $display("FAIL buf_read: rd_req on port %0d with 0 words buffered, required >=1", ip);
               end
            end
            checks++;
            if (issued - accepted > 2) begin
               errors++;
               $display("FAIL outstanding: %0d words outstanding, required <=2", issued - accepted);
            end
            if (out_valid && out_ready) begin
               checks++;
               a.data = out_data; a.port = out_port; a.sop = out_sop; a.eop = out_eop;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL word_unexpected: got port=%0d data=%0d sop=%0d eop=%0d, required none",
                           a.port, a.data, a.sop, a.eop);
               end else begin
                  e = exp_q.pop_front();
                  if (a !== e) begin
                     errors++;
                     $display("FAIL word: got port=%0d data=%0d sop=%0d eop=%0d, required port=%0d data=%0d sop=%0d eop=%0d",
                              a.port, a.data, a.sop, a.eop, e.port, e.data, e.sop, e.eop);
                  end else begin
                     $display("word port=%0d data=%0d sop=%0d eop=%0d", a.port, a.data, a.sop, a.eop);
                  end
               end
               accepted++;
               out_cnt++;
            end
            if (rd_req) begin
               issued++;
               rd_cnt++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic wr_word(input int port, input int data, input int len);
      wr_req     = 1'b1;
      wr_ip      = N'(port);
      wr_data    = N'(data);
      packet_len = 8'(len);
      step();
      wr_req = 1'b0;
   endtask

   task automatic wr_pkt(input int port, input int base, input int len);
      for (int i = 0; i < len; i++) wr_word(port, base + i, len);
   endtask

   task automatic exp_pkt(input int port, input int base, input int len);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.data = N'(base + i);
         w.port = N'(port);
         w.sop  = (i == 0);
         w.eop  = (i == len - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      chk(name, exp_q.size(), 0);
      repeat (3) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int o0;
      int n;
      rst = 1'b1; wr_req = 1'b0; wr_ip = '0; packet_len = '0; wr_data = '0;
      out_ready = 1'b1; force_empty = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_rd_req", int'(rd_req), 0);
      chk("rst_ip", int'(ip), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_port", int'(out_port), 0);
      chk("rst_out_sop", int'(out_sop), 0);
      chk("rst_out_eop", int'(out_eop), 0);
      chk("rst_len_overflow", int'(len_overflow), 0);
      step();

      // Single 3-word packet on port 0
      r0 = rd_cnt;
      exp_pkt(0, 1, 3);
      wr_pkt(0, 1, 3);
      wait_done("single_drain");
      chk("single_rd_count", rd_cnt - r0, 3);
      chk("single_ip", int'(ip), 0);

      // Round-robin: 0 served first, then 3 before 5, then a new port-0 packet
      r0 = rd_cnt;
      exp_pkt(0, 10, 3); exp_pkt(3, 30, 2); exp_pkt(5, 50, 2); exp_pkt(0, 13, 2);
      wr_pkt(0, 10, 3); wr_pkt(5, 50, 2); wr_pkt(3, 30, 2); wr_pkt(0, 13, 2);
      wait_done("rr_drain");
      chk("rr_rd_count", rd_cnt - r0, 9);

      // Interleaved single-word writes to ports 1 and 2
      r0 = rd_cnt;
      exp_pkt(1, 100, 2); exp_pkt(2, 200, 2);
      wr_word(1, 100, 2);
      wr_word(2, 200, 2);
      wr_word(1, 101, 2);
      chk("interleave_no_early_rd", rd_cnt - r0, 0);
      wr_word(2, 201, 2);
      wait_done("interleave_drain");
      chk("interleave_rd_count", rd_cnt - r0, 4);

      // Buffer-empty stall, then backpressure mid-packet on port 4
      r0 = rd_cnt;
      force_empty = 1'b1;
      exp_pkt(4, 40, 4);
      wr_pkt(4, 40, 4);
      repeat (4) step();
      chk("empty_stall_rd", rd_cnt - r0, 0);
      chk("empty_stall_ip", int'(ip), 4);
      force_empty = 1'b0;
      o0 = out_cnt; n = 0;
      while (out_cnt == o0 && n < 50) begin step(); n++; end
      chk("bp_first_word_seen", int'(out_cnt != o0), 1);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_ip_held", int'(ip), 4);
      end
      out_ready = 1'b1;
      wait_done("bp_drain");
      chk("bp_rd_count", rd_cnt - r0, 4);

      // Maximum length packet (255 words) on port 2
      r0 = rd_cnt;
      exp_pkt(2, 1000, 255);
      wr_pkt(2, 1000, 255);
      wait_done("len255_drain");
      chk("len255_rd_count", rd_cnt - r0, 255);

      // Overflow: reader busy on a stalled port-7 packet while port 6 fills
      r0 = rd_cnt;
      out_ready = 1'b0;
      exp_pkt(7, 70, 10);
      for (int k = 0; k < 4; k++) exp_pkt(6, 60 + k, 1);
      wr_pkt(7, 70, 10);
      repeat (4) step();
      chk("ovf_stalled_rd", rd_cnt - r0, 2);
      for (int k = 0; k < 4; k++) wr_pkt(6, 60 + k, 1);
      chk("ovf_before_5th", int'(len_overflow), 0);
      wr_pkt(6, 64, 1);
      chk("ovf_after_5th", int'(len_overflow), 1);
      out_ready = 1'b1;
      wait_done("ovf_drain");
      chk("ovf_rd_count", rd_cnt - r0, 14);
      chk("ovf_sticky", int'(len_overflow), 1);

      // Reset in the middle of a packet read
      r0 = rd_cnt;
      exp_pkt(3, 80, 6);
      wr_pkt(3, 80, 6);
      n = 0;
      while (rd_cnt == r0 && n < 50) begin step(); n++; end
      chk("midrst_reached_read", int'(rd_cnt != r0), 1);
      step();
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rd_req", int'(rd_req), 0);
      chk("midrst_ip", int'(ip), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_out_port", int'(out_port), 0);
      chk("midrst_out_sop", int'(out_sop), 0);
      chk("midrst_out_eop", int'(out_eop), 0);
      chk("midrst_len_overflow", int'(len_overflow), 0);
      step();
      r0 = rd_cnt;
      repeat (10) step();
      chk("midrst_no_rd", rd_cnt - r0, 0);

      // Recovery after reset: port 0 has first priority again
      r0 = rd_cnt;
      exp_pkt(0, 90, 2);
      wr_pkt(0, 90, 2);
      wait_done("recover_drain");
      chk("recover_rd_count", rd_cnt - r0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
